vn_control_unit: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 16-bit Von Neumann processor.
- Owns PC, IR and the latched zero flag.
- Shares the single unified memory port between instruction fetch and LOAD/STORE.
- Drives register-file addresses, write enables and the 4-bit ALU opcode; the register file and ALU live in the external datapath.

---
 rtl/vn_control_unit_pkg.sv | 49 ++++
 rtl/vn_instr_decode.sv | 40 ++++
 rtl/vn_control_unit.sv | 171 +++++++++++++++++
 tb/tb_vn_control_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vn_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vn_control_unit_pkg
// Description : Shared definitions for the 16-bit Von Neumann sequencer.
//               Holds the opcode map (shared with the external ALU), the
//               sequencer state encoding and the decoded-instruction bundle.
// Revision    : 1.0  initial release
// ============================================================================
package vn_control_unit_pkg;

    // Opcode map, IR[15:12]. ALU opcodes are forwarded verbatim to the ALU.
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b0110;
    localparam logic [3:0] OP_LOAD  = 4'b0111;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_JMP   = 4'b1001;
    localparam logic [3:0] OP_BEQZ  = 4'b1010;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Sequencer states; the encoding is visible on the debug 'state' port.
    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // Decoded view of one instruction word.
    typedef struct packed {
        logic        is_alu;
        logic        is_load;
        logic        is_store;
        logic        is_jmp;
        logic        is_beqz;
        logic        is_halt;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [11:0] target;
    } decode_t;

endpackage : vn_control_unit_pkg
`default_nettype wire

// File: rtl/vn_instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : vn_instr_decode
// Description : Purely combinational instruction decoder. Splits a 16-bit
//               instruction word into class flags and register/target fields.
//               Any opcode not listed decodes as NOP (all flags clear).
// Ports       : i_ir  [15:0] instruction word
//               o_dec        decoded bundle (decode_t)
// Revision    : 1.0  initial release
// ============================================================================
module vn_instr_decode
    import vn_control_unit_pkg::*;
(
    input  logic [15:0] i_ir,
    output decode_t     o_dec
);

    logic [3:0] w_op;
    assign w_op = i_ir[15:12];

    always_comb begin
        o_dec          = '0;
        o_dec.rd       = i_ir[11:8];
        o_dec.rs1      = i_ir[7:4];
        o_dec.rs2      = i_ir[3:0];
        o_dec.target   = i_ir[11:0];
        unique case (w_op)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR,  OP_XOR, OP_NOT : o_dec.is_alu   = 1'b1;
            OP_LOAD                : o_dec.is_load  = 1'b1;
            OP_STORE               : o_dec.is_store = 1'b1;
            OP_JMP                 : o_dec.is_jmp   = 1'b1;
            OP_BEQZ                : o_dec.is_beqz  = 1'b1;
            OP_HALT                : o_dec.is_halt  = 1'b1;
            default                : ;
        endcase
    end

endmodule : vn_instr_decode
`default_nettype wire

// File: rtl/vn_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : vn_control_unit
// Description : Multi-cycle fetch/decode/execute sequencer. Owns PC, IR and
//               the latched zero flag, arbitrates the single memory port
//               between instruction fetch and LOAD/STORE, and steers the
//               external register file and ALU.
// Ports       : clk, reset (sync, active-high)
//               mem_rdata/mem_ready           memory response
//               rs1_data                      LOAD/STORE address from RF
//               alu_zero                      ALU zero output
//               mem_req/mem_we/mem_addr       memory request
//               rf_raddr1/rf_raddr2/rf_waddr  register-file addresses
//               rf_we/wb_sel                  write-back control
//               alu_opcode                    ALU operation (EXECUTE only)
//               pc/halted/state               status and debug
// Revision    : 1.0  initial release
// ============================================================================
module vn_control_unit
    import vn_control_unit_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic              alu_zero,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        rf_raddr1,
    output logic [3:0]        rf_raddr2,
    output logic [3:0]        rf_waddr,
    output logic              rf_we,
    output logic              wb_sel,
    output logic [3:0]        alu_opcode,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [2:0]        state
);

    localparam logic [ADDR_W-1:0] c_pc_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state_q, w_state_d;
    logic [ADDR_W-1:0] r_pc_q,    w_pc_d;
    logic [DATA_W-1:0] r_ir_q,    w_ir_d;
    logic              r_zflag_q, w_zflag_d;

    decode_t           w_dec;
    logic [ADDR_W-1:0] w_target;

    logic              w_mem_req;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_rf_we;
    logic              w_wb_sel;
    logic [3:0]        w_alu_opcode;
    logic              w_halted;

    vn_instr_decode u_decode (
        .i_ir  (r_ir_q[15:0]),
        .o_dec (w_dec)
    );

    // Branch targets are 12-bit absolute addresses, zero-extended.
    assign w_target = {{(ADDR_W-12){1'b0}}, w_dec.target};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_FETCH;
            r_pc_q    <= RESET_PC;
            r_ir_q    <= '0;
            r_zflag_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_ir_q    <= w_ir_d;
            r_zflag_q <= w_zflag_d;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_pc_d       = r_pc_q;
        w_ir_d       = r_ir_q;
        w_zflag_d    = r_zflag_q;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_pc_q;
        w_rf_we      = 1'b0;
        w_wb_sel     = 1'b0;
        w_alu_opcode = 4'b0000;
        w_halted     = 1'b0;

        unique case (r_state_q)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_d    = mem_rdata;
                    w_pc_d    = r_pc_q + c_pc_one;
                    w_state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (w_dec.is_alu) begin
                    w_state_d = ST_EXECUTE;
                end else if (w_dec.is_load || w_dec.is_store) begin
                    w_state_d = ST_MEM;
                end else if (w_dec.is_halt) begin
                    w_state_d = ST_HALT;
                end else begin
                    // JMP, BEQZ and NOP all return straight to fetch.
                    if (w_dec.is_jmp || (w_dec.is_beqz && r_zflag_q)) begin
                        w_pc_d = w_target;
                    end
                    w_state_d = ST_FETCH;
                end
            end

            ST_EXECUTE: begin
                w_alu_opcode = r_ir_q[15:12];
                w_rf_we      = 1'b1;
                w_zflag_d    = alu_zero;
                w_state_d    = ST_FETCH;
            end

            ST_MEM: begin
                w_mem_req  = 1'b1;
                w_mem_we   = w_dec.is_store;
                w_mem_addr = rs1_data[ADDR_W-1:0];
                if (mem_ready) begin
                    // Load data is written back in the very cycle it arrives.
                    w_rf_we   = w_dec.is_load;
                    w_wb_sel  = w_dec.is_load;
                    w_state_d = ST_FETCH;
                end
            end

            ST_HALT: begin
                w_halted = 1'b1;
            end

            default: begin
                w_state_d = ST_FETCH;
            end
        endcase
    end

    // Strobes are masked while reset is high so an outstanding request is
    // dropped at once rather than completing against a reset sequencer.
    assign mem_req    = w_mem_req & ~reset;
    assign mem_we     = w_mem_we  & ~reset;
    assign rf_we      = w_rf_we   & ~reset;
    assign wb_sel     = w_wb_sel  & ~reset;
    assign halted     = w_halted  & ~reset;
    assign alu_opcode = reset ? 4'b0000 : w_alu_opcode;
    assign mem_addr   = w_mem_addr;

    assign rf_raddr1  = w_dec.rs1;
    assign rf_raddr2  = w_dec.rs2;
    assign rf_waddr   = w_dec.rd;
    assign pc         = r_pc_q;
    assign state      = r_state_q;

endmodule : vn_control_unit
`default_nettype wire

// File: tb/tb_vn_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vn_control_unit
// Description : Self-checking bench. An instruction-level model (PC, zero
//               flag, per-class cycle sequence) predicts every output of the
//               sequencer while memory wait states, register data and ALU
//               zero are randomised. A second instance with RESET_PC=0xFFFF
//               covers PC wrap-around.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vn_control_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] rs1_data;
    logic        alu_zero;
    logic        mem_req, mem_we, rf_we, wb_sel, halted;
    logic [15:0] mem_addr, pc;
    logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr, alu_opcode;
    logic [2:0]  state;

    vn_control_unit dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rs1_data(rs1_data), .alu_zero(alu_zero), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_opcode(alu_opcode), .pc(pc), .halted(halted),
        .state(state)
    );

    // Wrap-around instance
    logic        wr_reset, wr_ready;
    logic [15:0] wr_rdata;
    logic        wr_mem_req, wr_mem_we, wr_rf_we, wr_wb_sel, wr_halted;
    logic [15:0] wr_mem_addr, wr_pc;
    logic [3:0]  wr_raddr1, wr_raddr2, wr_waddr, wr_alu_opcode;
    logic [2:0]  wr_state;

    vn_control_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .reset(wr_reset), .mem_rdata(wr_rdata), .mem_ready(wr_ready),
        .rs1_data(16'h0000), .alu_zero(1'b0), .mem_req(wr_mem_req),
        .mem_we(wr_mem_we), .mem_addr(wr_mem_addr), .rf_raddr1(wr_raddr1),
        .rf_raddr2(wr_raddr2), .rf_waddr(wr_waddr), .rf_we(wr_rf_we),
        .wb_sel(wr_wb_sel), .alu_opcode(wr_alu_opcode), .pc(wr_pc),
        .halted(wr_halted), .state(wr_state)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_pc;
    bit          m_z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reset with random junk on the memory inputs; strobes must read 0 while
    // reset is held, PC and state must return to their reset values.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'($urandom);
        @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we",  mem_we, 0);
        chk("rst_rf_we",   rf_we, 0);
        chk("rst_wb_sel",  wb_sel, 0);
        chk("rst_halted",  halted, 0);
        chk("rst_aluop",   alu_opcode, 0);
        chk("rst_pc",      pc, 16'h0000);
        chk("rst_state",   state, 0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        m_pc      = 16'h0000;
        m_z       = 1'b0;
    endtask

    // Runs one instruction through the model and the DUT. fw/mw are wait
    // cycles before mem_ready in FETCH and MEM; abort resets mid-MEM-wait.
    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                             input logic [15:0] rs1, input bit az, input bit abort);
        logic [3:0] op;
        bit is_alu, is_ld, is_st, is_jmp, is_bz, is_hlt, rdy;
        op     = ins[15:12];
        is_alu = (op >= 4'd1) && (op <= 4'd6);
        is_ld  = (op == 4'd7);
        is_st  = (op == 4'd8);
        is_jmp = (op == 4'd9);
        is_bz  = (op == 4'd10);
        is_hlt = (op == 4'd15);

        for (int k = 0; k <= fw; k++) begin
            @(negedge clk);
            rdy       = (k == fw);
            mem_ready = rdy;
            mem_rdata = rdy ? ins : 16'($urandom);
            rs1_data  = 16'($urandom);
            alu_zero  = 1'($urandom);
            #1;
            chk("fetch_state", state, 0);
            chk("fetch_req",   mem_req, 1);
            chk("fetch_we",    mem_we, 0);
            chk("fetch_addr",  mem_addr, m_pc);
            chk("fetch_rf_we", rf_we, 0);
        end
        m_pc = m_pc + 16'd1;

        @(negedge clk);
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
        #1;
        chk("dec_state", state, 1);
        chk("dec_pc",    pc, m_pc);
        chk("dec_req",   mem_req, 0);
        chk("dec_rf_we", rf_we, 0);
        chk("dec_aluop", alu_opcode, 0);
        if (is_jmp || (is_bz && m_z)) m_pc = {4'h0, ins[11:0]};

        if (is_alu) begin
            @(negedge clk);
            alu_zero  = az;
            mem_ready = 1'($urandom);
            #1;
            chk("ex_state", state, 2);
            chk("ex_aluop", alu_opcode, op);
            chk("ex_rf_we", rf_we, 1);
            chk("ex_wbsel", wb_sel, 0);
            chk("ex_waddr", rf_waddr, ins[11:8]);
            chk("ex_ra1",   rf_raddr1, ins[7:4]);
            chk("ex_ra2",   rf_raddr2, ins[3:0]);
            chk("ex_req",   mem_req, 0);
            m_z = az;
        end

        if (is_ld || is_st) begin
            for (int k = 0; k <= mw; k++) begin
                if (abort && k == mw) begin
                    do_reset();
                    return;
                end
                @(negedge clk);
                rdy       = (k == mw);
                mem_ready = rdy;
                rs1_data  = rs1;
                #1;
                chk("mem_state", state, 3);
                chk("mem_req",   mem_req, 1);
                chk("mem_we",    mem_we, is_st);
                chk("mem_addr",  mem_addr, rs1);
                chk("mem_rf_we", rf_we, is_ld && rdy);
                chk("mem_wbsel", wb_sel, is_ld && rdy);
                chk("mem_ra1",   rf_raddr1, ins[7:4]);
                chk("mem_ra2",   rf_raddr2, ins[3:0]);
                if (is_ld && rdy) chk("mem_waddr", rf_waddr, ins[11:8]);
            end
        end

        if (is_hlt) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                mem_ready = 1'($urandom);
                #1;
                chk("halt_flag",  halted, 1);
                chk("halt_req",   mem_req, 0);
                chk("halt_state", state, 4);
            end
            do_reset();
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  op;
        int          mw;
        bit          ab;

        reset = 1'b1; mem_ready = 1'b0; mem_rdata = '0; rs1_data = '0; alu_zero = 1'b0;
        wr_reset = 1'b1; wr_ready = 1'b0; wr_rdata = '0;
        repeat (2) @(posedge clk);

        // PC wrap from 0xFFFF on the second instance
        @(negedge clk);
        wr_reset = 1'b0;
        wr_ready = 1'b1;
        wr_rdata = 16'h0000;
        #1;
        chk("wrap_pc0",   wr_pc, 16'hFFFF);
        chk("wrap_addr0", wr_mem_addr, 16'hFFFF);
        chk("wrap_req0",  wr_mem_req, 1);
        @(negedge clk);
        wr_ready = 1'b0;
        #1;
        chk("wrap_pc1",    wr_pc, 16'h0000);
        chk("wrap_state1", wr_state, 1);

        do_reset();

        // Directed sequence
        run_instr(16'h1123, 0, 0, 16'h0, 1'b0, 1'b0);
        run_instr(16'h2455, 0, 0, 16'h0, 1'b1, 1'b0);
        run_instr(16'hA00A, 0, 0, 16'h0, 1'b0, 1'b0);  // taken -> 0x000A
        run_instr(16'h2455, 1, 0, 16'h0, 1'b0, 1'b0);
        run_instr(16'hA00A, 0, 0, 16'h0, 1'b0, 1'b0);  // not taken
        run_instr(16'h7120, 0, 2, 16'h0040, 1'b0, 1'b0);
        run_instr(16'h2455, 0, 0, 16'h0, 1'b1, 1'b0);
        run_instr(16'h8034, 0, 1, 16'h1234, 1'b0, 1'b0);
        run_instr(16'hA00A, 0, 0, 16'h0, 1'b0, 1'b0);  // zflag survives STORE
        run_instr(16'h9FFF, 0, 0, 16'h0, 1'b0, 1'b0);
        run_instr(16'h7120, 2, 3, 16'h0040, 1'b0, 1'b1); // reset mid-wait
        run_instr(16'hF000, 0, 0, 16'h0, 1'b0, 1'b0);

        // Random stream
        for (int i = 0; i < 250; i++) begin
            r  = $urandom;
            op = r[15:12];
            if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h0;
            mw = $urandom_range(0, 3);
            ab = ($urandom_range(0, 7) == 0) && (mw > 0);
            run_instr({op, r[11:0]}, $urandom_range(0, 3), mw, 16'($urandom),
                      1'($urandom), ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_vn_control_unit
`default_nettype wire
